uart_bram_loader: RTL
=====================

Name: uart_bram_loader

Overview:
- UART receiver plus command parser that writes 32-bit words into the design's single-port BRAM.
- Drives the BRAM write port (we/addr/din), so host-side memory contents can be changed at run time without rebuilding the INIT_FILE image.
- Sits directly upstream of the BRAM, on the board rx pin, in the same clock domain.

Parameters:
- BOARD_CK, 32000000, clock frequency in Hz.
- BAUD, 115200, UART bit rate.
- ADDR_WIDTH, 13, BRAM word address width.
- DATA_WIDTH, 32, BRAM word width. Fixed at 32; other values are unsupported.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- rx  input  1  asynchronous UART line, idle high.
- we  output  1  BRAM write strobe, one-cycle pulse.
- addr  output  ADDR_WIDTH  BRAM word address.
- din  output  32  BRAM write data.
- frame_err  output  1  one-cycle pulse on a bad stop bit.
- wr_count  output  16  number of completed writes, wraps at 0xFFFF->0.

Behaviour:
- Reset (reset==0 sampled on a clk edge):
  - we=0, addr=0, din=0, frame_err=0, wr_count=0.
  - Both FSMs go to IDLE; synchronizer flops are set to 1.
  - A reset mid-byte or mid-packet discards all partial data.
- rx goes through a 2-flop synchronizer; only the synchronized value is used.
- CLKS_PER_BIT = BOARD_CK/BAUD, integer division (277 at the defaults). HALF = CLKS_PER_BIT/2.
- RX FSM states: R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE: a synchronized 0 moves to R_START with the bit counter cleared.
  - R_START: after HALF clocks, resample. If the line is 1, treat it as a glitch and return to R_IDLE. If 0, go to R_DATA.
  - R_DATA: sample every CLKS_PER_BIT clocks, 8 bits, LSB first.
  - R_STOP: sample once after CLKS_PER_BIT clocks.
    - Stop=1: pulse byte_valid (internal) for one cycle, go to R_IDLE.
    - Stop=0: pulse frame_err for one cycle, discard the byte, and wait in R_STOP until the line is 1 before returning to R_IDLE.
- Packet FSM states: P_IDLE, P_AH, P_AL, P_DATA, P_WRITE. It advances only on byte_valid.
  - P_IDLE:
    - 0x57 'W' -> P_AH.
    - 0x4E 'N' -> P_DATA, with pending address = addr+1, wrapping modulo 2^ADDR_WIDTH.
    - Any other byte is ignored.
  - P_AH: take the address high byte -> P_AL.
  - P_AL: take the address low byte -> P_DATA.
  - The pending address is the low ADDR_WIDTH bits of {hi,lo}; upper bits are discarded.
  - P_DATA: collect 4 bytes, little-endian (first byte -> bits 7:0), then go to P_WRITE.
  - P_WRITE lasts exactly one cycle:
    - we=1, addr=pending address, din=assembled word.
    - wr_count increments.
    - Next state is P_IDLE.
- Write latency: we rises on the clk edge immediately after the byte_valid cycle of the 4th data byte.
- addr and din are registered. They update on the edge that raises we and hold their values until the next write. Outside P_WRITE, we=0.
- A frame_err while the packet FSM is not in P_IDLE aborts the packet: go to P_IDLE, no write, addr/din unchanged.
- 'N' issued after reset writes to address 1, since addr resets to 0.
- There is no inter-byte timeout; a stalled packet waits indefinitely.

Test Plan:
1. Bench runs with BOARD_CK=1600, BAUD=100 (CLKS_PER_BIT=16). Hold reset=0 for 3 clks with rx toggling -> we=0, addr=0, din=0, wr_count=0.
2. Send 0x57,0x00,0x05,0x78,0x56,0x34,0x12 -> exactly one we pulse with addr=5, din=0x12345678, wr_count=1; we arrives 1 clk after the last stop-bit sample.
3. After test 2, send 0x4E,0xEF,0xBE,0xAD,0xDE -> we pulse with addr=6, din=0xDEADBEEF, wr_count=2.
4. Send 0x57,0xFF,0xFF, then data 0x01,0,0,0, then 0x4E + 4 bytes -> first write at addr=0x1FFF, second at addr=0 (wrap); upper address bits ignored.
5. Send 0x57,0x00,0x02, then a byte with stop bit forced 0, then 4 valid bytes -> one frame_err pulse, no write, addr/din unchanged; a following full 'W' packet writes normally.
6. Drive a 5-clk low glitch on rx while idle -> no byte_valid, no frame_err. Assert reset mid-packet (after 3 data bytes) -> no write, wr_count unchanged by the partial packet (0 if no prior writes), and a subsequent full packet writes correctly.

Source files
------------

// File: rtl/uart_bram_loader_if.sv
// BRAM write-port bundle driven by the UART loader.
// The master side drives a single-cycle write strobe with its address and data.
interface uart_bram_loader_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;

  modport master (output we, output addr, output din);
  modport slave  (input  we, input  addr, input  din);
endinterface

// File: rtl/uart_bram_loader.sv
// UART receiver plus packet parser that writes 32-bit words into a BRAM.
// Packets: 'W' addr_hi addr_lo d0 d1 d2 d3  or  'N' d0 d1 d2 d3 (next address).
// Data bytes are little-endian; a framing error aborts any packet in progress.
module uart_bram_loader #(
  parameter int BOARD_CK   = 32000000,
  parameter int BAUD       = 115200,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  uart_bram_loader_if.master   bram,
  output logic                 frame_err,
  output logic [15:0]          wr_count
);

  localparam int CLKS_PER_BIT = BOARD_CK / BAUD;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_NEXT  = 8'h4E;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {P_IDLE, P_AH, P_AL, P_DATA, P_WRITE} pkt_state_t;

  logic                  rx_meta;
  logic                  rx_sync;

  rx_state_t             rx_state;
  logic [CNT_W-1:0]      clk_cnt;
  logic [2:0]            bit_idx;
  logic [7:0]            shreg;
  logic                  byte_valid;
  logic                  stop_wait;

  pkt_state_t            pkt_state;
  logic [7:0]            addr_hi;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [1:0]            byte_cnt;
  logic [DATA_WIDTH-9:0] data_sr;

  // Two-flop synchronizer for the asynchronous rx line; idles high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Receive FSM: mid-bit sampling, 8N1, LSB first; a bad stop bit waits for idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_state   <= R_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      stop_wait  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          if (!rx_sync) begin
            rx_state <= R_START;
            clk_cnt  <= '0;
            bit_idx  <= '0;
          end
        end
        R_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt  <= '0;
            bit_idx  <= '0;
            rx_state <= rx_sync ? R_IDLE : R_DATA;
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end
        R_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              rx_state <= R_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end
        R_STOP: begin
          if (stop_wait) begin
            if (rx_sync) begin
              stop_wait <= 1'b0;
              rx_state  <= R_IDLE;
            end
          end else if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              rx_state   <= R_IDLE;
            end else begin
              frame_err <= 1'b1;
              stop_wait <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  // Packet FSM: parses commands, assembles the word, issues a one-cycle write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pkt_state <= P_IDLE;
      addr_hi   <= '0;
      pend_addr <= '0;
      byte_cnt  <= '0;
      data_sr   <= '0;
      bram.we   <= 1'b0;
      bram.addr <= '0;
      bram.din  <= '0;
      wr_count  <= '0;
    end else begin
      bram.we <= 1'b0;
      if (frame_err && (pkt_state != P_IDLE)) begin
        pkt_state <= P_IDLE;
      end else begin
        case (pkt_state)
          P_IDLE: begin
            if (byte_valid) begin
              if (shreg == CMD_WRITE) begin
                pkt_state <= P_AH;
              end else if (shreg == CMD_NEXT) begin
                pend_addr <= bram.addr + ADDR_WIDTH'(1);
                byte_cnt  <= '0;
                pkt_state <= P_DATA;
              end
            end
          end
          P_AH: begin
            if (byte_valid) begin
              addr_hi   <= shreg;
              pkt_state <= P_AL;
            end
          end
          P_AL: begin
            if (byte_valid) begin
              pend_addr <= ADDR_WIDTH'({addr_hi, shreg});
              byte_cnt  <= '0;
              pkt_state <= P_DATA;
            end
          end
          P_DATA: begin
            if (byte_valid) begin
              if (byte_cnt == 2'd3) begin
                bram.we   <= 1'b1;
                bram.addr <= pend_addr;
                bram.din  <= {shreg, data_sr};
                wr_count  <= wr_count + 16'd1;
                pkt_state <= P_WRITE;
              end else begin
                case (byte_cnt)
                  2'd0:    data_sr[7:0]   <= shreg;
                  2'd1:    data_sr[15:8]  <= shreg;
                  default: data_sr[23:16] <= shreg;
                endcase
                byte_cnt <= byte_cnt + 2'd1;
              end
            end
          end
          P_WRITE: pkt_state <= P_IDLE;
          default: pkt_state <= P_IDLE;
        endcase
      end
    end
  end

endmodule
